// File: rtl/jtag_cmd_sequencer_pkg.sv
// Shared types and constants for the JTAG sequencer and the JTAG master engine.
package jtag_pkg;

    localparam int DATA_INSTRUCTION_DEF = 6;
    localparam int DATA_FIFO_DEF        = 8;

    // TMS walks used by the engine, shifted out LSB first.
    localparam logic [4:0] TMS_TAP_RESET     = 5'b11111; // any state -> Test-Logic-Reset
    localparam logic [3:0] TMS_IDLE_TO_SH_IR = 4'b0011;  // Run-Test/Idle -> Shift-IR
    localparam logic [2:0] TMS_IDLE_TO_SH_DR = 3'b001;   // Run-Test/Idle -> Shift-DR
    localparam logic [1:0] TMS_EXIT_TO_IDLE  = 2'b01;    // Exit1 -> Update -> Run-Test/Idle

    typedef enum logic [1:0] {
        CMD_IR      = 2'd0,
        CMD_DR      = 2'd1,
        CMD_DR_CONF = 2'd2,
        CMD_END     = 2'd3
    } cmd_kind_t;

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_LOAD_IR,
        S_LOAD_DR,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ERR
    } seq_state_t;

    // Payload bytes needed for a DR shift of the given bit length (9-bit so 255+7 cannot wrap).
    function automatic logic [8:0] byte_count(input logic [7:0] bits);
        return ({1'b0, bits} + 9'd7) >> 3;
    endfunction

endpackage

// File: rtl/jtag_cmd_sequencer_if.sv
// Host-side command and payload handshake of the JTAG command sequencer.
interface jtag_cmd_sequencer_if #(
    parameter int DATA_INSTRUCTION = 6,
    parameter int DATA_FIFO        = 8
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [1:0]                  cmd_kind;
    logic [7:0]                  cmd_len;
    logic [DATA_INSTRUCTION-1:0] cmd_instr;
    logic                        byte_valid;
    logic                        byte_ready;
    logic [DATA_FIFO-1:0]        byte_data;

    modport master (
        output cmd_valid, cmd_kind, cmd_len, cmd_instr, byte_valid, byte_data,
        input  cmd_ready, byte_ready
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_len, cmd_instr, byte_valid, byte_data,
        output cmd_ready, byte_ready
    );
endinterface

// File: rtl/jtag_cmd_sequencer_watchdog.sv
// Loadable down-counter guarding the gap between the work pulse and busy rising.
module jtag_seq_watchdog #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    // Load wins over counting; the counter parks at zero once it gets there.
    always_ff @(posedge clk) begin
        if (rst)                        count <= '0;
        else if (load)                  count <= load_value;
        else if (enable && count != '0) count <= count - 1'b1;
    end

    assign expired = (count == '0);
endmodule

// File: rtl/jtag_cmd_sequencer.sv
// Feeds the JTAG master engine: loads its FIFOs from host commands, launches it and tracks busy.
module jtag_cmd_sequencer
    import jtag_pkg::*;
#(
    parameter int DATA_INSTRUCTION = DATA_INSTRUCTION_DEF,
    parameter int DATA_FIFO        = DATA_FIFO_DEF,
    parameter int MAX_LEN          = 128,
    parameter int TIMEOUT          = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    jtag_cmd_sequencer_if.slave         host,
    output logic                        wr_instruction,
    output logic [DATA_INSTRUCTION-1:0] wdata_instruction,
    input  logic                        full_instruction,
    output logic                        wr_data,
    output logic [DATA_FIFO-1:0]        wdata_data,
    input  logic                        full_data,
    output logic                        op,
    output logic                        end_op,
    output logic                        conf_op,
    output logic [7:0]                  len,
    output logic                        work,
    input  logic                        busy,
    output logic                        done,
    output logic                        len_err,
    output logic                        timeout_err,
    output logic [15:0]                 cmd_count
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    seq_state_t                  state;
    cmd_kind_t                   kind_r;
    logic [7:0]                  len_r;
    logic [DATA_INSTRUCTION-1:0] instr_r;
    logic [8:0]                  bytes_left;
    logic                        len_bad;
    logic                        wd_expired;

    assign len_bad = (host.cmd_len == 8'd0) || (host.cmd_len > 8'(MAX_LEN));

    // FIFO strobes are gated by rst so a reset landing mid-load never writes.
    assign wr_instruction    = !rst && (state == S_LOAD_IR) && !full_instruction;
    assign wdata_instruction = instr_r;
    assign host.byte_ready   = !rst && (state == S_LOAD_DR) && !full_data;
    assign wr_data           = host.byte_valid && host.byte_ready;
    assign wdata_data        = host.byte_data;

    jtag_seq_watchdog #(.WIDTH(WD_W)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .load       (state == S_LAUNCH),
        .load_value (WD_W'(TIMEOUT)),
        .enable     (state == S_WAIT_BUSY),
        .expired    (wd_expired)
    );

    // Sequencer FSM; every host/engine control output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_BOOT;
            host.cmd_ready <= 1'b0;
            work           <= 1'b0;
            op             <= 1'b0;
            end_op         <= 1'b0;
            conf_op        <= 1'b0;
            len            <= 8'd0;
            done           <= 1'b0;
            len_err        <= 1'b0;
            timeout_err    <= 1'b0;
            cmd_count      <= 16'd0;
            kind_r         <= CMD_IR;
            len_r          <= 8'd0;
            instr_r        <= '0;
            bytes_left     <= 9'd0;
        end else begin
            work    <= 1'b0;
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                S_BOOT: begin
                    // Engine is busy with its TAP reset until it drops busy.
                    if (!busy) begin
                        state          <= S_IDLE;
                        host.cmd_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!host.cmd_ready) begin
                        // Re-open after a rejected DR command.
                        host.cmd_ready <= 1'b1;
                    end else if (host.cmd_valid) begin
                        host.cmd_ready <= 1'b0;
                        kind_r         <= cmd_kind_t'(host.cmd_kind);
                        len_r          <= host.cmd_len;
                        instr_r        <= host.cmd_instr;
                        bytes_left     <= byte_count(host.cmd_len);
                        case (cmd_kind_t'(host.cmd_kind))
                            CMD_IR:      state <= S_LOAD_IR;
                            CMD_DR:      if (len_bad) len_err <= 1'b1; else state <= S_LOAD_DR;
                            CMD_DR_CONF: if (len_bad) len_err <= 1'b1; else state <= S_LAUNCH;
                            default:     state <= S_LAUNCH;
                        endcase
                    end
                end
                S_LOAD_IR: begin
                    if (wr_instruction) state <= S_LAUNCH;
                end
                S_LOAD_DR: begin
                    if (wr_data) begin
                        bytes_left <= bytes_left - 9'd1;
                        if (bytes_left == 9'd1) state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // Engine selects stay stable until done; it re-reads op/len mid-shift.
                    work    <= 1'b1;
                    op      <= (kind_r == CMD_DR) || (kind_r == CMD_DR_CONF);
                    conf_op <= (kind_r == CMD_DR_CONF);
                    end_op  <= (kind_r == CMD_END);
                    len     <= ((kind_r == CMD_DR) || (kind_r == CMD_DR_CONF)) ? len_r : 8'd0;
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        state       <= S_ERR;
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy) begin
                        done           <= 1'b1;
                        cmd_count      <= cmd_count + 16'd1;
                        op             <= 1'b0;
                        end_op         <= 1'b0;
                        conf_op        <= 1'b0;
                        len            <= 8'd0;
                        host.cmd_ready <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    // S_ERR: parked with handshakes closed until rst.
                    state <= S_ERR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Scoreboard bench for jtag_cmd_sequencer with a simple engine busy model.
module tb_jtag_cmd_sequencer;
    import jtag_pkg::*;

    localparam int DI      = 6;
    localparam int DF      = 8;
    localparam int MAX_LEN = 128;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic       op;
        logic       end_op;
        logic       conf_op;
        logic [7:0] len;
    } launch_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_cmd_sequencer_if #(.DATA_INSTRUCTION(DI), .DATA_FIFO(DF)) host ();

    logic          wr_instruction;
    logic [DI-1:0] wdata_instruction;
    logic          full_instruction = 1'b0;
    logic          wr_data;
    logic [DF-1:0] wdata_data;
    logic          full_data = 1'b0;
    logic          op, end_op, conf_op, work, busy, done, len_err, timeout_err;
    logic [7:0]    len;
    logic [15:0]   cmd_count;

    logic boot_busy = 1'b1;
    logic eng_busy  = 1'b0;
    logic eng_en    = 1'b1;
    int   eng_cycles = 40;
    assign busy = boot_busy | eng_busy;

    jtag_cmd_sequencer #(
        .DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .host(host),
        .wr_instruction(wr_instruction), .wdata_instruction(wdata_instruction),
        .full_instruction(full_instruction),
        .wr_data(wr_data), .wdata_data(wdata_data), .full_data(full_data),
        .op(op), .end_op(end_op), .conf_op(conf_op), .len(len), .work(work), .busy(busy),
        .done(done), .len_err(len_err), .timeout_err(timeout_err), .cmd_count(cmd_count)
    );

    int total = 0;
    int bad   = 0;
    int n_work = 0, n_done = 0, n_lenerr = 0, n_wrd = 0, n_wri = 0;

    logic [DI-1:0] exp_ir[$];
    logic [DF-1:0] exp_byte[$];
    launch_t       exp_launch[$];
    launch_t       held, got, want;
    logic [DI-1:0] want_ir;
    logic [DF-1:0] want_byte;
    bit            inflight = 0;

    function automatic launch_t mk(input logic o, input logic e, input logic c, input logic [7:0] l);
        launch_t r;
        r.op = o; r.end_op = e; r.conf_op = c; r.len = l;
        return r;
    endfunction

    // Engine model: busy rises one cycle after work and stays up eng_cycles cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (work && eng_en && !rst) begin
                @(posedge clk); #1 eng_busy = 1'b1;
                repeat (eng_cycles) @(posedge clk);
                #1 eng_busy = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every strobe and checks held engine selects.
    always @(negedge clk) begin
        if (rst) begin
            inflight = 0;
        end else begin
            got = {op, end_op, conf_op, len};
            if (wr_instruction) begin
                n_wri++; total++;
                if (exp_ir.size() == 0) begin
                    bad++; $display("FAIL ir_write unexpected data=%h", wdata_instruction);
                end else begin
                    want_ir = exp_ir.pop_front();
                    if (wdata_instruction !== want_ir || full_instruction) begin
                        bad++; $display("FAIL ir_write got=%h exp=%h full=%b", wdata_instruction, want_ir, full_instruction);
                    end
                end
            end
            if (wr_data) begin
                n_wrd++; total++;
                if (exp_byte.size() == 0) begin
                    bad++; $display("FAIL dr_write unexpected data=%h", wdata_data);
                end else begin
                    want_byte = exp_byte.pop_front();
                    if (wdata_data !== want_byte || full_data) begin
                        bad++; $display("FAIL dr_write got=%h exp=%h full=%b", wdata_data, want_byte, full_data);
                    end
                end
            end
            if (work) begin
                n_work++; total++;
                if (exp_launch.size() == 0) begin
                    bad++; $display("FAIL launch unexpected sel=%h", got);
                end else begin
                    want = exp_launch.pop_front();
                    if (got !== want) begin
                        bad++; $display("FAIL launch got=%h exp=%h", got, want);
                    end
                    held = want;
                    inflight = 1;
                end
            end else if (inflight && !done) begin
                total++;
                if (got !== held) begin
                    bad++; $display("FAIL held_sel got=%h exp=%h", got, held);
                end
            end
            if (done) begin
                n_done++; total++;
                inflight = 0;
                if (got !== '0) begin
                    bad++; $display("FAIL done_clear got=%h exp=0", got);
                end
            end
            if (len_err) n_lenerr++;
        end
    end

    task automatic send_cmd(input cmd_kind_t k, input logic [7:0] l, input logic [DI-1:0] ins);
        int n = 0;
        host.cmd_valid = 1'b1; host.cmd_kind = k; host.cmd_len = l; host.cmd_instr = ins;
        forever begin
            @(posedge clk);
            if (host.cmd_ready) break;
            if (++n > 200) begin
                total++; bad++; $display("FAIL cmd_handshake timeout kind=%0d", k); break;
            end
        end
        #1 host.cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [DF-1:0] d);
        int n = 0;
        host.byte_valid = 1'b1; host.byte_data = d;
        forever begin
            @(posedge clk);
            if (host.byte_ready) break;
            if (++n > 200) begin
                total++; bad++; $display("FAIL byte_handshake timeout data=%h", d); break;
            end
        end
        #1 host.byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int start = n_done;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (n_done > start) return;
        end
        total++; bad++; $display("FAIL wait_done timeout after %0d cycles", max);
    endtask

    task automatic check_count(input string name, input logic [15:0] exp);
        @(negedge clk);
        total++;
        if (cmd_count !== exp) begin
            bad++; $display("FAIL %s cmd_count got=%0d exp=%0d", name, cmd_count, exp);
        end
        total++;
        if (exp_ir.size() + exp_byte.size() + exp_launch.size() != 0) begin
            bad++; $display("FAIL %s leftover ir=%0d byte=%0d launch=%0d exp=0", name,
                            exp_ir.size(), exp_byte.size(), exp_launch.size());
        end
    endtask

    // Boot: hold busy after reset, cmd_ready rises one cycle after busy falls.
    task automatic boot(input string name, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if ({host.cmd_ready, host.byte_ready, wr_instruction, wr_data, work, op, end_op,
                 conf_op, len, done, len_err, timeout_err, cmd_count} !== '0) begin
                bad++; $display("FAIL %s outputs_nonzero cycle=%0d ready=%b work=%b cnt=%0d exp=0",
                                name, i, host.cmd_ready, work, cmd_count);
            end
        end
        @(posedge clk); #1 boot_busy = 1'b0;
        @(negedge clk);
        total++;
        if (host.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL %s ready_early got=%b exp=0", name, host.cmd_ready);
        end
        @(negedge clk);
        total++;
        if (host.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_rise got=%b exp=1", name, host.cmd_ready);
        end
    endtask

    task automatic test_reset();
        host.cmd_valid = 1'b0; host.cmd_kind = 2'd0; host.cmd_len = 8'd0; host.cmd_instr = '0;
        host.byte_valid = 1'b1; host.byte_data = 8'hEE;  // stray payload must be ignored
        rst = 1'b1; boot_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        boot("boot", 20);
    endtask

    task automatic test_ir();
        exp_ir.push_back(6'h2A);
        exp_launch.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
        send_cmd(CMD_IR, 8'd0, 6'h2A);
        wait_done(200);
        host.byte_valid = 1'b0;
        check_count("ir", 16'd1);
    endtask

    task automatic test_dr_stall();
        exp_byte.push_back(8'h11); exp_byte.push_back(8'h22); exp_byte.push_back(8'h33);
        exp_launch.push_back(mk(1'b1, 1'b0, 1'b0, 8'd20));
        send_cmd(CMD_DR, 8'd20, '0);
        send_byte(8'h11);
        full_data = 1'b1; host.byte_valid = 1'b1; host.byte_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (host.byte_ready !== 1'b0) begin
                bad++; $display("FAIL dr_full byte_ready got=%b exp=0", host.byte_ready);
            end
            @(posedge clk); #1;
        end
        full_data = 1'b0;
        send_byte(8'h22);
        send_byte(8'h33);
        wait_done(200);
        check_count("dr", 16'd2);
        total++;
        if (n_wrd != 3) begin
            bad++; $display("FAIL dr_writes got=%0d exp=3", n_wrd);
        end
    endtask

    task automatic test_conf_end();
        int wr0 = n_wrd + n_wri;
        exp_launch.push_back(mk(1'b1, 1'b0, 1'b1, 8'd8));
        exp_launch.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0));
        send_cmd(CMD_DR_CONF, 8'd8, '0);
        wait_done(200);
        send_cmd(CMD_END, 8'd77, '0);
        wait_done(200);
        check_count("conf_end", 16'd4);
        total++;
        if (n_wrd + n_wri != wr0) begin
            bad++; $display("FAIL conf_end fifo_writes got=%0d exp=%0d", n_wrd + n_wri, wr0);
        end
    endtask

    task automatic test_dr_max();
        logic [DF-1:0] b[16];
        for (int i = 0; i < 16; i++) begin
            b[i] = DF'($urandom_range(0, 255));
            exp_byte.push_back(b[i]);
        end
        exp_launch.push_back(mk(1'b1, 1'b0, 1'b0, 8'(MAX_LEN)));
        send_cmd(CMD_DR, 8'(MAX_LEN), '0);
        for (int i = 0; i < 16; i++) send_byte(b[i]);
        wait_done(200);
        check_count("dr_max", 16'd5);
    endtask

    task automatic test_len_err();
        logic [7:0] bad_len[4];
        cmd_kind_t  bad_kind[4];
        int w0 = n_work, e0 = n_lenerr;
        bad_len[0] = 8'd0;  bad_len[1] = 8'(MAX_LEN + 1); bad_len[2] = 8'd255; bad_len[3] = 8'd0;
        bad_kind[0] = CMD_DR; bad_kind[1] = CMD_DR; bad_kind[2] = CMD_DR; bad_kind[3] = CMD_DR_CONF;
        for (int i = 0; i < 4; i++) begin
            send_cmd(bad_kind[i], bad_len[i], '0);
            @(negedge clk);
            total++;
            if (len_err !== 1'b1) begin
                bad++; $display("FAIL len_err_pulse case=%0d got=%b exp=1", i, len_err);
            end
            @(negedge clk);
            total++;
            if (host.cmd_ready !== 1'b1 || len_err !== 1'b0) begin
                bad++; $display("FAIL len_err_recover case=%0d ready=%b len_err=%b exp=1/0",
                                i, host.cmd_ready, len_err);
            end
        end
        total++;
        if (n_lenerr - e0 != 4 || n_work != w0) begin
            bad++; $display("FAIL len_err_count errs=%0d works=%0d exp=4/0", n_lenerr - e0, n_work - w0);
        end
        check_count("len_err", 16'd5);
    endtask

    task automatic test_timeout();
        int w0 = n_work;
        int n = 0;
        eng_en = 1'b0;
        exp_launch.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0));
        send_cmd(CMD_END, 8'd0, '0);
        while (n_work == w0 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (timeout_err !== 1'b1 && n < TIMEOUT + 20) begin @(negedge clk); n++; end
        total++;
        if (n < TIMEOUT || n > TIMEOUT + 2) begin
            bad++; $display("FAIL timeout_latency got=%0d exp=%0d..%0d", n, TIMEOUT, TIMEOUT + 2);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (timeout_err !== 1'b1 || host.cmd_ready !== 1'b0 || work !== 1'b0) begin
                bad++; $display("FAIL timeout_park err=%b ready=%b work=%b exp=1/0/0",
                                timeout_err, host.cmd_ready, work);
            end
        end
        @(posedge clk); #1 rst = 1'b1; boot_busy = 1'b1; eng_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        boot("reboot", 5);
        exp_ir.push_back(6'h15);
        exp_launch.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
        send_cmd(CMD_IR, 8'd0, 6'h15);
        wait_done(200);
        check_count("after_reboot", 16'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_ir();
        test_dr_stall();
        test_conf_end();
        test_dr_max();
        test_len_err();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtag_cmd_sequencer.md
Name: jtag_cmd_sequencer

Overview:
Upstream feeder for the JTAG master engine. It accepts host commands (IR shift, DR shift, DR config shift, end sequence) and their payload bytes. It fills the engine's instruction and data FIFOs, then drives op/end_op/conf_op/len/work and tracks the engine's busy to completion. It also provides command counting, a start watchdog and length checking.

Parameters:
DATA_INSTRUCTION, 6, instruction register width in bits.
DATA_FIFO, 8, data FIFO word width in bits.
MAX_LEN, 128, largest legal DR shift length in bits (at most 255).
TIMEOUT, 64, cycles allowed between work pulse and busy rising.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
cmd_kind  in  2  0=IR, 1=DR, 2=DR_CONF, 3=END.
cmd_len  in  8  DR/DR_CONF shift length in bits.
cmd_instr  in  DATA_INSTRUCTION  IR opcode (IR only).
byte_valid  in  1  payload byte offered.
byte_ready  out  1  payload byte accepted.
byte_data  in  DATA_FIFO  payload byte.
wr_instruction  out  1  instruction FIFO write strobe.
wdata_instruction  out  DATA_INSTRUCTION  instruction FIFO write data.
full_instruction  in  1  instruction FIFO full.
wr_data  out  1  data FIFO write strobe.
wdata_data  out  DATA_FIFO  data FIFO write data.
full_data  in  1  data FIFO full.
op  out  1  engine transaction type: 1=data, 0=instruction.
end_op  out  1  engine end sequence select.
conf_op  out  1  engine config-pattern select.
len  out  8  engine DR length.
work  out  1  engine start pulse.
busy  in  1  engine busy.
done  out  1  one-cycle pulse when a command completes.
len_err  out  1  one-cycle pulse when a DR command is rejected.
timeout_err  out  1  sticky flag; engine did not start.
cmd_count  out  16  completed command count; wraps.

Behaviour:
- Reset values: cmd_ready=0, byte_ready=0, wr_*=0, work=0, op/end_op/conf_op=0, len=0, done=0, len_err=0, timeout_err=0, cmd_count=0. FSM state after reset is S_BOOT.
- S_BOOT: the engine runs a TAP reset after its own reset (busy=1). Wait for busy==0, then go to S_IDLE.
- S_IDLE: cmd_ready=1. On a handshake, latch kind/len/instr into registers.
  - IR -> S_LOAD_IR.
  - DR -> if cmd_len==0 or cmd_len>MAX_LEN, pulse len_err next cycle and stay in S_IDLE. Otherwise set nbytes=(cmd_len+7)>>3, computed 9-bit, and go to S_LOAD_DR.
  - DR_CONF -> length check as DR, then S_LAUNCH. No payload is loaded; the engine supplies its own pattern.
  - END -> S_LAUNCH.
- S_LOAD_IR: wr_instruction = !full_instruction, combinational, with wdata_instruction = latched instr. On the write, go to S_LAUNCH. While full, hold.
- S_LOAD_DR: byte_ready = !full_data. wr_data = byte_valid&&byte_ready and wdata_data = byte_data, combinational. Decrement the byte counter per write. When the counter reaches 0 after a write, go to S_LAUNCH. byte_valid asserted outside S_LOAD_DR is ignored (byte_ready=0).
- S_LAUNCH: work=1 for exactly one cycle. Drive op (1 for DR/DR_CONF), conf_op (1 for DR_CONF), end_op (1 for END) and len (latched, 0 for IR/END). Load the watchdog with TIMEOUT. Go to S_WAIT_BUSY.
- op/end_op/conf_op/len are held stable from S_LAUNCH until done. The engine re-reads op and len mid-transaction.
- S_WAIT_BUSY: busy==1 -> S_WAIT_DONE. If the watchdog reaches 0 first -> set timeout_err and go to S_ERR.
- S_WAIT_DONE: on busy==0, pulse done, increment cmd_count (16-bit wrap 0xFFFF->0), clear op/end_op/conf_op/len, and return to S_IDLE.
- S_ERR: all handshake outputs and strobes are 0. Exit only by rst.
- Reset mid-operation: FSM returns to S_BOOT. Partially loaded FIFO contents are the FIFO owner's concern; the sequencer asserts no strobe during reset.
- A command is never accepted while a transaction is outstanding: one command in flight at most.

Decomposition:
- Shared package jtag_pkg:
  - cmd_kind_t enum (CMD_IR, CMD_DR, CMD_DR_CONF, CMD_END).
  - Sequencer state enum.
  - DATA_INSTRUCTION/DATA_FIFO defaults.
  - The engine TMS constants, reused by the engine.
- One sub-module, jtag_seq_watchdog: a loadable down-counter with load, enable and expired outputs.

Test Plan:
- Boot: after rst, hold busy=1 for 20 cycles then drop -> cmd_ready rises exactly one cycle after busy falls. All outputs stay at their reset values until then.
- IR 6'h2A, engine model raises busy 1 cycle after work for 40 cycles -> one wr_instruction with data 6'h2A, one work pulse with op=0, done after busy falls, cmd_count=1.
- DR len=20, bytes 0x11,0x22,0x33 with full_data asserted for 3 cycles mid-stream -> exactly 3 wr_data in order with no write while full. Then work with op=1, len=20, conf_op=0, held until done.
- DR_CONF len=8, then END -> no FIFO writes. First work has conf_op=1. Second work has end_op=1, len=0. cmd_count increments by 2.
- DR len=0 and DR len=MAX_LEN+1 -> len_err pulses twice, no work, cmd_ready returns the next cycle.
- Work issued and busy never rises -> timeout_err=1 at TIMEOUT cycles, cmd_ready=0 thereafter. After rst, timeout_err=0 and the FSM re-enters S_BOOT.
